// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: shared opcode/funct3 encodings and default widths for the integer execution stage.
package alu_unit_pkg;
   localparam int ROB_IDX_W = 4;
   localparam int XLEN = 32;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I integer/branch/jump compute; unknown encodings flag illegal.
module alu_core import alu_unit_pkg::*; (
   input  logic [6:0]      opcode_i,
   input  logic [2:0]      funct3_i,
   input  logic            funct7_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] val1_i,
   input  logic [XLEN-1:0] val2_i,
   output logic [XLEN-1:0] val_o,
   output logic            jump_o,
   output logic [XLEN-1:0] pc_o,
   output logic            illegal_o
);
   logic [XLEN-1:0] b, pc4, alu, sra;
   logic [4:0] sh;
   logic take, br_ok;
   always_comb begin
      b = (opcode_i == OPC_OP) ? val2_i : imm_i;
      sh = b[4:0];
      pc4 = pc_i + XLEN'(4);
      sra = $signed(val1_i) >>> sh;
      case (funct3_i)
         F3_ADD:  alu = (opcode_i == OPC_OP && funct7_i) ? val1_i - b : val1_i + b;
         F3_SLL:  alu = val1_i << sh;
         F3_SLT:  alu = XLEN'($signed(val1_i) < $signed(b));
         F3_SLTU: alu = XLEN'(val1_i < b);
         F3_XOR:  alu = val1_i ^ b;
         F3_SR:   alu = funct7_i ? sra : val1_i >> sh;
         F3_OR:   alu = val1_i | b;
         default: alu = val1_i & b;
      endcase
      br_ok = 1'b1;
      case (funct3_i)
         F3_BEQ:  take = val1_i == val2_i;
         F3_BNE:  take = val1_i != val2_i;
         F3_BLT:  take = $signed(val1_i) < $signed(val2_i);
         F3_BGE:  take = $signed(val1_i) >= $signed(val2_i);
         F3_BLTU: take = val1_i < val2_i;
         F3_BGEU: take = val1_i >= val2_i;
         default: begin take = 1'b0; br_ok = 1'b0; end
      endcase
      val_o = '0;
      jump_o = 1'b0;
      pc_o = pc4;
      illegal_o = 1'b0;
      case (opcode_i)
         OPC_LUI:   val_o = imm_i;
         OPC_AUIPC: val_o = pc_i + imm_i;
         OPC_JAL:   begin val_o = pc4; jump_o = 1'b1; pc_o = pc_i + imm_i; end
         OPC_JALR:  begin val_o = pc4; jump_o = 1'b1; pc_o = (val1_i + imm_i) & ~XLEN'(1); end
         OPC_BR:    begin jump_o = take; pc_o = take ? pc_i + imm_i : pc4; illegal_o = !br_ok; end
         OPC_OPIMM, OPC_OP: val_o = alu;
         default:   illegal_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: integer execution stage wrapping alu_core with a registered one-cycle result broadcast.
module alu_unit #(
   parameter int ROB_IDX_W = alu_unit_pkg::ROB_IDX_W,
   parameter int XLEN = alu_unit_pkg::XLEN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 alu_en,
   input  logic [6:0]           alu_opcode,
   input  logic [2:0]           alu_funct3,
   input  logic                 alu_funct7,
   input  logic [XLEN-1:0]      alu_imm,
   input  logic [XLEN-1:0]      alu_pc,
   input  logic [ROB_IDX_W-1:0] alu_rob_pos,
   input  logic [XLEN-1:0]      alu_val1,
   input  logic [XLEN-1:0]      alu_val2,
   output logic                 result,
   output logic [ROB_IDX_W-1:0] result_rob_pos,
   output logic [XLEN-1:0]      result_val,
   output logic                 result_jump,
   output logic [XLEN-1:0]      result_pc,
   output logic                 result_illegal
);
   logic [XLEN-1:0] val_d, pc_d, val_q, pc_q;
   logic jump_d, illegal_d, result_q, jump_q, illegal_q;
   logic [ROB_IDX_W-1:0] pos_q;
   alu_core u_core (
      .opcode_i(alu_opcode), .funct3_i(alu_funct3), .funct7_i(alu_funct7),
      .imm_i(alu_imm), .pc_i(alu_pc), .val1_i(alu_val1), .val2_i(alu_val2),
      .val_o(val_d), .jump_o(jump_d), .pc_o(pc_d), .illegal_o(illegal_d)
   );
   // Data fields only load on a dispatch; a dropped result leaves them stale by design.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= 1'b0;
         pos_q <= '0;
         val_q <= '0;
         jump_q <= 1'b0;
         pc_q <= '0;
         illegal_q <= 1'b0;
      end else if (rollback) begin
         result_q <= 1'b0;
      end else if (rdy) begin
         result_q <= alu_en;
         if (alu_en) begin
            pos_q <= alu_rob_pos;
            val_q <= val_d;
            jump_q <= jump_d;
            pc_q <= pc_d;
            illegal_q <= illegal_d;
         end
      end
   end
   assign result = result_q;
   assign result_rob_pos = pos_q;
   assign result_val = val_q;
   assign result_jump = jump_q;
   assign result_pc = pc_q;
   assign result_illegal = illegal_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed self-checking bench for alu_unit with hand-computed expectations.
module tb_alu_unit;
   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
   localparam logic [6:0] BR = 7'b1100011, OPIMM = 7'b0010011, OP = 7'b0110011;
   logic clk = 1'b0, rst_n = 1'b1, rdy = 1'b1, rollback = 1'b0, alu_en = 1'b0, alu_funct7 = 1'b0;
   logic [6:0] alu_opcode = '0;
   logic [2:0] alu_funct3 = '0;
   logic [31:0] alu_imm = '0, alu_pc = '0, alu_val1 = '0, alu_val2 = '0;
   logic [3:0] alu_rob_pos = '0;
   logic result, result_jump, result_illegal;
   logic [3:0] result_rob_pos;
   logic [31:0] result_val, result_pc;
   int checks = 0, errors = 0;
   alu_unit dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
      .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
      .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos),
      .alu_val1(alu_val1), .alu_val2(alu_val2), .result(result),
      .result_rob_pos(result_rob_pos), .result_val(result_val), .result_jump(result_jump),
      .result_pc(result_pc), .result_illegal(result_illegal)
   );
   always #5 clk = ~clk;
   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [3:0] pos, input logic [31:0] v1, input logic [31:0] v2);
      @(negedge clk);
      alu_opcode = opc; alu_funct3 = f3; alu_funct7 = f7; alu_imm = imm;
      alu_pc = pc; alu_rob_pos = pos; alu_val1 = v1; alu_val2 = v2; alu_en = 1'b1;
   endtask
   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [3:0] pos, input logic [31:0] v1, input logic [31:0] v2);
      drive(opc, f3, f7, imm, pc, pos, v1, v2);
      @(posedge clk); #1;
      alu_en = 1'b0;
   endtask
   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({result, result_jump, result_illegal} !== 3'b000) begin errors++; $display("FAIL reset flags got %b exp 000", {result, result_jump, result_illegal}); end
      checks++; if ({result_rob_pos, result_val, result_pc} !== 68'd0) begin errors++; $display("FAIL reset fields got %h exp 0", {result_rob_pos, result_val, result_pc}); end
      @(negedge clk); rst_n = 1'b1;
   endtask
   task automatic test_reset_mid;
      issue(OP, 3'b000, 1'b0, 32'd0, 32'h10, 4'd3, 32'd5, 32'd7);
      checks++; if (result !== 1'b1) begin errors++; $display("FAIL mid pre result got %b exp 1", result); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({result, result_rob_pos, result_val, result_pc} !== 69'd0) begin errors++; $display("FAIL mid reset got %h exp 0", {result, result_rob_pos, result_val, result_pc}); end
      @(negedge clk); rst_n = 1'b1;
   endtask
   task automatic test_add_sub;
      issue(OP, 3'b000, 1'b0, 32'd0, 32'h100, 4'd1, 32'd5, 32'd7);
      checks++; if ({result, result_rob_pos, result_val} !== {1'b1, 4'd1, 32'd12}) begin errors++; $display("FAIL add got %b %h %h exp 1 1 0000000c", result, result_rob_pos, result_val); end
      checks++; if ({result_jump, result_pc, result_illegal} !== {1'b0, 32'h104, 1'b0}) begin errors++; $display("FAIL add ctl got %b %h %b exp 0 00000104 0", result_jump, result_pc, result_illegal); end
      issue(OP, 3'b000, 1'b1, 32'd0, 32'h100, 4'd2, 32'd5, 32'd7);
      checks++; if (result_val !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub got %h exp fffffffe", result_val); end
      @(posedge clk); #1;
      checks++; if ({result, result_val} !== {1'b0, 32'hFFFFFFFE}) begin errors++; $display("FAIL idle hold got %b %h exp 0 fffffffe", result, result_val); end
   endtask
   task automatic test_opimm;
      issue(OPIMM, 3'b000, 1'b1, 32'd3, 32'h0, 4'd4, 32'd10, 32'd99);
      checks++; if (result_val !== 32'd13) begin errors++; $display("FAIL addi got %h exp 0000000d", result_val); end
      issue(OPIMM, 3'b101, 1'b1, 32'd4, 32'h0, 4'd5, 32'h80000000, 32'd0);
      checks++; if (result_val !== 32'hF8000000) begin errors++; $display("FAIL srai got %h exp f8000000", result_val); end
      issue(OPIMM, 3'b101, 1'b0, 32'd4, 32'h0, 4'd5, 32'h80000000, 32'd0);
      checks++; if (result_val !== 32'h08000000) begin errors++; $display("FAIL srli got %h exp 08000000", result_val); end
      issue(OP, 3'b001, 1'b0, 32'd0, 32'h0, 4'd6, 32'd1, 32'h21);
      checks++; if (result_val !== 32'd2) begin errors++; $display("FAIL sll got %h exp 00000002", result_val); end
      issue(OP, 3'b010, 1'b0, 32'd0, 32'h0, 4'd6, 32'hFFFFFFFE, 32'd3);
      checks++; if (result_val !== 32'd1) begin errors++; $display("FAIL slt got %h exp 00000001", result_val); end
      issue(OP, 3'b011, 1'b0, 32'd0, 32'h0, 4'd6, 32'hFFFFFFFE, 32'd3);
      checks++; if (result_val !== 32'd0) begin errors++; $display("FAIL sltu got %h exp 00000000", result_val); end
      issue(OPIMM, 3'b100, 1'b0, 32'h0F0F, 32'h0, 4'd6, 32'hFF00, 32'd0);
      checks++; if (result_val !== 32'hF00F) begin errors++; $display("FAIL xori got %h exp 0000f00f", result_val); end
      issue(OP, 3'b110, 1'b0, 32'd0, 32'h0, 4'd6, 32'hF0, 32'h0F);
      checks++; if (result_val !== 32'hFF) begin errors++; $display("FAIL or got %h exp 000000ff", result_val); end
      issue(OP, 3'b111, 1'b0, 32'd0, 32'h0, 4'd6, 32'hF0, 32'h3C);
      checks++; if (result_val !== 32'h30) begin errors++; $display("FAIL and got %h exp 00000030", result_val); end
   endtask
   task automatic test_branch_jump;
      issue(BR, 3'b100, 1'b0, 32'h20, 32'h100, 4'd7, 32'hFFFFFFFF, 32'd1);
      checks++; if ({result_jump, result_pc, result_val} !== {1'b1, 32'h120, 32'd0}) begin errors++; $display("FAIL blt got %b %h %h exp 1 00000120 0", result_jump, result_pc, result_val); end
      issue(BR, 3'b110, 1'b0, 32'h20, 32'h100, 4'd7, 32'hFFFFFFFF, 32'd1);
      checks++; if ({result_jump, result_pc} !== {1'b0, 32'h104}) begin errors++; $display("FAIL bltu got %b %h exp 0 00000104", result_jump, result_pc); end
      issue(BR, 3'b000, 1'b0, 32'h40, 32'h200, 4'd7, 32'd8, 32'd8);
      checks++; if ({result_jump, result_pc} !== {1'b1, 32'h240}) begin errors++; $display("FAIL beq got %b %h exp 1 00000240", result_jump, result_pc); end
      issue(BR, 3'b111, 1'b0, 32'h40, 32'h200, 4'd7, 32'd7, 32'd8);
      checks++; if ({result_jump, result_pc} !== {1'b0, 32'h204}) begin errors++; $display("FAIL bgeu got %b %h exp 0 00000204", result_jump, result_pc); end
      issue(BR, 3'b010, 1'b0, 32'h40, 32'h200, 4'd7, 32'd8, 32'd8);
      checks++; if ({result, result_illegal, result_jump, result_pc} !== {1'b1, 1'b1, 1'b0, 32'h204}) begin errors++; $display("FAIL br f3 010 got %b %b %b %h exp 1 1 0 00000204", result, result_illegal, result_jump, result_pc); end
      issue(JALR, 3'b000, 1'b0, 32'd0, 32'h300, 4'd8, 32'h203, 32'd0);
      checks++; if ({result_jump, result_pc, result_val, result_illegal} !== {1'b1, 32'h202, 32'h304, 1'b0}) begin errors++; $display("FAIL jalr got %b %h %h %b exp 1 00000202 00000304 0", result_jump, result_pc, result_val, result_illegal); end
      issue(JAL, 3'b000, 1'b0, 32'hFFFFFFF0, 32'h100, 4'd8, 32'd0, 32'd0);
      checks++; if ({result_jump, result_pc, result_val} !== {1'b1, 32'hF0, 32'h104}) begin errors++; $display("FAIL jal got %b %h %h exp 1 000000f0 00000104", result_jump, result_pc, result_val); end
      issue(AUIPC, 3'b000, 1'b0, 32'h2000, 32'h1000, 4'd8, 32'd0, 32'd0);
      checks++; if ({result_jump, result_val} !== {1'b0, 32'h3000}) begin errors++; $display("FAIL auipc got %b %h exp 0 00003000", result_jump, result_val); end
      issue(LUI, 3'b000, 1'b0, 32'h12345000, 32'hFFFFFFFC, 4'd8, 32'd0, 32'd0);
      checks++; if ({result_val, result_pc} !== {32'h12345000, 32'h0}) begin errors++; $display("FAIL lui wrap got %h %h exp 12345000 00000000", result_val, result_pc); end
   endtask
   task automatic test_rollback;
      drive(OP, 3'b000, 1'b0, 32'd0, 32'h0, 4'd10, 32'd1, 32'd1);
      rollback = 1'b1;
      @(posedge clk); #1;
      alu_en = 1'b0; rollback = 1'b0;
      checks++; if ({result, result_rob_pos} !== {1'b0, 4'd8}) begin errors++; $display("FAIL rollback got %b %h exp 0 8", result, result_rob_pos); end
   endtask
   task automatic test_rdy_hold;
      issue(OP, 3'b000, 1'b0, 32'd0, 32'h0, 4'd5, 32'd1, 32'd1);
      rdy = 1'b0;
      drive(OP, 3'b000, 1'b0, 32'd0, 32'h0, 4'd6, 32'd9, 32'd9);
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({result, result_rob_pos, result_val} !== {1'b1, 4'd5, 32'd2}) begin errors++; $display("FAIL rdy hold got %b %h %h exp 1 5 00000002", result, result_rob_pos, result_val); end
      alu_en = 1'b0; rdy = 1'b1;
      @(posedge clk); #1;
      checks++; if ({result, result_rob_pos} !== {1'b0, 4'd5}) begin errors++; $display("FAIL rdy release got %b %h exp 0 5", result, result_rob_pos); end
   endtask
   task automatic test_back_to_back;
      for (int i = 1; i <= 3; i++) begin
         issue(OPIMM, 3'b000, 1'b0, 32'(i), 32'h0, 4'(i), 32'd100, 32'd0);
         checks++; if ({result, result_rob_pos, result_val} !== {1'b1, 4'(i), 32'(100 + i)}) begin errors++; $display("FAIL b2b %0d got %b %h %h exp 1 %h %h", i, result, result_rob_pos, result_val, 4'(i), 32'(100 + i)); end
      end
   endtask
   task automatic test_illegal;
      issue(7'h7F, 3'b000, 1'b0, 32'h55, 32'h40, 4'd9, 32'd3, 32'd4);
      checks++; if ({result, result_rob_pos, result_illegal, result_jump} !== {1'b1, 4'd9, 1'b1, 1'b0}) begin errors++; $display("FAIL illegal flags got %b %h %b %b exp 1 9 1 0", result, result_rob_pos, result_illegal, result_jump); end
      checks++; if ({result_pc, result_val} !== {32'h44, 32'd0}) begin errors++; $display("FAIL illegal data got %h %h exp 00000044 0", result_pc, result_val); end
   endtask
   initial begin
      test_reset;
      test_reset_mid;
      test_add_sub;
      test_opimm;
      test_branch_jump;
      test_rollback;
      test_rdy_hold;
      test_back_to_back;
      test_illegal;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
